nfu3_coef_loader: RTL and testbench

Write-side master for the NFU-3 sigmoid coefficient table. It accepts a stream of packed {ai,bi} segment coefficients over a valid/ready handshake, typically from the control buffer or DMA. It writes them into the shared coefficient RAM one segment per cycle, driving coef data, write address and the load strobe. It reports busy/done status to the top-level controller so NFU-3 is not used mid-reload.

---
 rtl/nfu3_coef_loader_pkg.sv | 23 ++
 rtl/nfu3_coef_loader.sv | 121 ++++++++++++
 tb/tb_nfu3_coef_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/nfu3_coef_loader_pkg.sv
// Shared NFU-3 coefficient-loader definitions: default sizes, FSM state
// encodings and the layout of the packed {ai,bi} coefficient word.
package nfu3_coef_loader_pkg;

  // Default sizes: 16-bit ai/bi, 16 segments, 4-bit RAM address.
  localparam int N_DEF        = 16;
  localparam int NUM_SEG_DEF  = 16;
  localparam int SEG_BITS_DEF = 4;

  // Loader FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Field positions in the 2N-bit word: ai in the upper half, bi in the lower half.
  localparam int AI_LSB = N_DEF;
  localparam int AI_MSB = 2 * N_DEF - 1;
  localparam int BI_LSB = 0;
  localparam int BI_MSB = N_DEF - 1;

endpackage

// File: rtl/nfu3_coef_loader.sv
// NFU-3 sigmoid coefficient table loader: takes NUM_SEG packed {ai,bi} words
// over valid/ready and writes them to the coefficient RAM at addresses
// 0..NUM_SEG-1, one entry per cycle, with busy/done/overrun status.
module nfu3_coef_loader
  import nfu3_coef_loader_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int NUM_SEG  = NUM_SEG_DEF,
  parameter int SEG_BITS = SEG_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [2*N-1:0]      i_data,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [2*N-1:0]      o_coef,
  output logic [SEG_BITS-1:0] o_coef_addr,
  output logic                o_load_coef,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_overrun
);

  // One extra counter bit so NUM_SEG == 2**SEG_BITS needs no special handling.
  localparam int CNT_W = SEG_BITS + 1;
  localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(NUM_SEG - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]      coef_q, coef_d;
  logic [SEG_BITS-1:0] addr_q, addr_d;
  logic                load_q, load_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
  logic                accept;

  // Ready is the only combinational output; abort blocks the same-cycle word.
  assign o_ready = (state_q == ST_LOAD) && !i_abort;
  assign accept  = i_valid && o_ready;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    coef_d    = coef_q;
    addr_d    = addr_q;
    load_d    = 1'b0;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d   = ST_LOAD;
          cnt_d     = '0;
          overrun_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (i_start) begin
          overrun_d = 1'b1;
        end
        if (i_abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          load_d = 1'b1;
          coef_d = i_data;
          addr_d = cnt_q[SEG_BITS-1:0];
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_SEG) begin
            // DONE coincides with the final write strobe.
            state_d = ST_DONE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      ST_DONE: begin
        if (i_start) begin
          overrun_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight write strobe at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      coef_q    <= '0;
      addr_q    <= '0;
      load_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      coef_q    <= coef_d;
      addr_q    <= addr_d;
      load_q    <= load_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_coef      = coef_q;
  assign o_coef_addr = addr_q;
  assign o_load_coef = load_q;
  assign o_done      = done_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nfu3_coef_loader.sv
// Scoreboard bench for nfu3_coef_loader: a reference model pushes expected
// RAM writes into a queue; a negedge monitor pops and compares every strobe
// and checks the status outputs each cycle.
module tb_nfu3_coef_loader;

  localparam int NUM_SEG = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] o_coef;
  logic [3:0]  o_coef_addr;
  logic        o_load_coef;
  logic        o_busy;
  logic        o_done;
  logic        o_overrun;

  nfu3_coef_loader dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_coef      (o_coef),
    .o_coef_addr (o_coef_addr),
    .o_load_coef (o_load_coef),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_overrun   (o_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    bit          last;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  // Reference model: "a load session is open; m_count words taken so far".
  bit          m_loading = 1'b0;
  bit          m_fin     = 1'b0;
  bit          m_ov      = 1'b0;
  int          m_count   = 0;
  int          last_addr = 0;
  logic [31:0] last_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the table-load rules, evaluated at each clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_loading = 1'b0;
      m_fin     = 1'b0;
      m_ov      = 1'b0;
      m_count   = 0;
      last_addr = 0;
      last_data = '0;
      exp_q.delete();
    end else begin
      bit was_fin;
      was_fin = m_fin;
      m_fin   = 1'b0;
      if (m_loading) begin
        if (i_start) m_ov = 1'b1;
        if (i_abort) begin
          m_loading = 1'b0;
          m_count   = 0;
        end else if (i_valid) begin
          exp_q.push_back('{addr: m_count, data: i_data, last: (m_count == NUM_SEG - 1)});
          m_count++;
          if (m_count == NUM_SEG) begin
            m_loading = 1'b0;
            m_fin     = 1'b1;
            m_count   = 0;
          end
        end
      end else if (was_fin) begin
        if (i_start) m_ov = 1'b1;
      end else if (i_start) begin
        m_loading = 1'b1;
        m_count   = 0;
        m_ov      = 1'b0;
      end
    end
  end

  // Monitor: status every cycle, one scoreboard pop per write strobe.
  always @(negedge clk) begin
    chk("busy", 64'(o_busy), 64'(m_loading | m_fin));
    chk("ready", 64'(o_ready), 64'(m_loading & ~i_abort));
    chk("overrun", 64'(o_overrun), 64'(m_ov));
    if (o_load_coef === 1'b1) begin
      chk("strobe_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        wr_t w;
        w = exp_q.pop_front();
        chk("coef_addr", 64'(o_coef_addr), 64'(w.addr));
        chk("coef_data", 64'(o_coef), 64'(w.data));
        chk("done_with_strobe", 64'(o_done), 64'(w.last));
        $display("write addr=%0d data=0x%08h done=%0b", o_coef_addr, o_coef, o_done);
        last_addr = w.addr;
        last_data = w.data;
      end
    end else begin
      chk("strobe_missing", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      chk("done_no_strobe", 64'(o_done), 64'd0);
      chk("addr_hold", 64'(o_coef_addr), 64'(last_addr));
      chk("coef_hold", 64'(o_coef), 64'(last_data));
    end
  end

  task automatic idle_valid(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      i_valid = 1'b1;
      i_data  = $urandom;
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  // One load session. vmode: 0 valid held, 1 valid toggling, 2 random.
  // abort_at / start_at / rst_at name the word index at which to act (-1 = never).
  task automatic load_run(input int vmode, input int abort_at, input int start_at, input int rst_at);
    bit extra_done = 1'b0;
    bit finished   = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b1;
    i_valid = 1'b0;
    i_abort = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      i_start = 1'b0;
      i_abort = 1'b0;
      if (!m_loading) begin
        finished = 1'b1;
        break;
      end
      if (vmode == 0)      i_valid = 1'b1;
      else if (vmode == 1) i_valid = (c % 2 == 0);
      else                 i_valid = 1'($urandom_range(0, 1));
      i_data = (vmode == 2) ? $urandom : 32'h0001_0000 + 32'(m_count);
      if (m_count == abort_at) i_abort = 1'b1;
      if (m_count == start_at && !extra_done) begin
        i_start    = 1'b1;
        extra_done = 1'b1;
      end
      if (rst_at >= 0 && m_count == rst_at) begin
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst_load_coef", 64'(o_load_coef), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        finished = 1'b1;
        break;
      end
    end
    i_valid = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    if (!finished) chk("load_timeout", 64'd0, 64'd1);
    $display("load vmode=%0d abort_at=%0d start_at=%0d rst_at=%0d ended", vmode, abort_at, start_at, rst_at);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_addr", 64'(o_coef_addr), 64'd0);
    chk("reset_coef", 64'(o_coef), 64'd0);

    idle_valid(4);
    load_run(0, -1, -1, -1);
    repeat (3) @(posedge clk);
    load_run(1, -1, -1, -1);
    repeat (2) @(posedge clk);
    load_run(0, 5, -1, -1);
    @(negedge clk);
    chk("post_abort_ready", 64'(o_ready), 64'd0);
    load_run(0, -1, -1, -1);
    load_run(0, -1, 7, -1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("overrun_sticky", 64'(o_overrun), 64'd1);
    load_run(2, -1, -1, -1);
    for (int r = 0; r < 6; r++) begin
      int ab, st;
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NUM_SEG - 1)) : -1;
      st = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, NUM_SEG - 1)) : -1;
      load_run(2, ab, st, -1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    load_run(0, -1, -1, 9);
    idle_valid(4);
    load_run(2, -1, -1, -1);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
